// File: rtl/uart_periph.sv
// uart_periph: memory-mapped UART with TX/RX FIFOs, 16x-oversampled receiver,
// programmable baud divisor, optional parity, sticky error flags and a level irq.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   addr      bus address; top IO_SEL_BITS select the block, addr[3:2] = register
//   wdata     bus write data
//   we        1 = write, 0 = read
//   req_valid one-cycle request strobe
//   rdata     registered read data (0 on writes), valid with rsp_valid
//   rsp_valid one-cycle completion, one clock after a selected request
//   txd       serial output, idle high
//   rxd       serial input, asynchronous to clk
//   irq       level interrupt
//
// Registers: 0 DATA, 1 STATUS, 2 CTRL, 3 BAUD_DIV.

// Show-ahead FIFO: rdata is the head entry whenever empty is low.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok != pop_ok) count <= push_ok ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

module uart_periph #(
  parameter int                     ADDR_WIDTH   = 32,
  parameter int                     DATA_WIDTH   = 32,
  parameter int                     IO_SEL_BITS  = 4,
  parameter logic [IO_SEL_BITS-1:0] UART_SEL     = IO_SEL_BITS'(4'h1),
  parameter int                     FIFO_DEPTH   = 16,
  parameter logic [15:0]            BAUD_DIV_RST = 16'd27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic                  req_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rsp_valid,
  output logic                  txd,
  input  logic                  rxd,
  output logic                  irq
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;

  // Bus decode
  logic       sel;
  logic [1:0] off;
  logic       wr_data, wr_status, wr_ctrl, wr_baud, rd_data;
  assign sel       = req_valid & (addr[ADDR_WIDTH-1 -: IO_SEL_BITS] == UART_SEL);
  assign off       = addr[3:2];
  assign wr_data   = sel & we & (off == 2'd0);
  assign wr_status = sel & we & (off == 2'd1);
  assign wr_ctrl   = sel & we & (off == 2'd2);
  assign wr_baud   = sel & we & (off == 2'd3);
  assign rd_data   = sel & ~we & (off == 2'd0);

  logic unused_bits;
  assign unused_bits = ^{addr[ADDR_WIDTH-IO_SEL_BITS-1:4], addr[1:0], wdata[DATA_WIDTH-1:16]};

  // Control / status state
  logic [6:0]  ctrl;
  logic [15:0] baud_div, baud_cnt, div_eff;
  logic [3:0]  flags;      // {parity_err, frame_err, rx_ovr, tx_ovf}
  logic [3:0]  flag_set, flag_clr;
  logic        tick;
  logic        tx_en, rx_en, par_en, par_odd, rx_ie, tx_ie, err_ie;
  assign {err_ie, tx_ie, rx_ie, par_odd, par_en, rx_en, tx_en} = ctrl;

  // A divisor of 0 behaves as 1, so the tick fires every clock.
  assign div_eff = (baud_div == 16'd0) ? 16'd1 : baud_div;
  assign tick    = (baud_cnt == div_eff - 16'd1);

  // FIFOs
  logic [7:0] tx_rdata, rx_rdata, rx_shift;
  logic       tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(wr_data), .pop(tx_pop), .wdata(wdata[7:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );
  uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rd_data), .wdata(rx_shift),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  // TX FSM
  uart_state_e tx_state, tx_state_n;
  logic [3:0]  tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_data, tx_data_n;
  logic        txd_n, tx_go, tx_busy;
  assign tx_go   = tx_en & ~tx_empty;
  assign tx_busy = (tx_state != S_IDLE);

  // NOTE: every variable gets a default at the top of a combinational block
  // (blocking assignments), so no path can leave one unassigned and infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_data_n  = tx_data;
    tx_pop     = 1'b0;
    txd_n      = 1'b1;
    if (tx_state == S_IDLE) begin
      if (tx_go) begin
        tx_state_n = S_START;
        tx_cnt_n   = '0;
        tx_data_n  = tx_rdata;
        tx_pop     = 1'b1;
      end
    end else if (tick) begin
      tx_cnt_n = tx_cnt + 4'd1;
      if (tx_cnt == 4'd15) begin
        case (tx_state)
          S_START: begin
            tx_state_n = S_DATA;
            tx_bit_n   = '0;
          end
          S_DATA: begin
            tx_bit_n = tx_bit + 3'd1;
            if (tx_bit == 3'd7) tx_state_n = par_en ? S_PARITY : S_STOP;
          end
          S_PARITY: tx_state_n = S_STOP;
          S_STOP: begin
            // Back-to-back: skip IDLE when another byte is waiting.
            if (tx_go) begin
              tx_state_n = S_START;
              tx_data_n  = tx_rdata;
              tx_pop     = 1'b1;
            end else begin
              tx_state_n = S_IDLE;
            end
          end
          default: tx_state_n = S_IDLE;
        endcase
      end
    end
    // txd is registered from the next state so the line never glitches.
    case (tx_state_n)
      S_START:  txd_n = 1'b0;
      S_DATA:   txd_n = tx_data_n[tx_bit_n];
      S_PARITY: txd_n = ^tx_data_n ^ par_odd;
      default:  txd_n = 1'b1;
    endcase
  end

  // RX: synchroniser, edge detect and FSM
  logic        rx_meta, rx_sync, rx_prev, rx_fall;
  uart_state_e rx_state, rx_state_n;
  logic [3:0]  rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift_n;
  logic        rx_frame_set, rx_par_set;
  assign rx_fall = rx_prev & ~rx_sync;

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    rx_push      = 1'b0;
    rx_frame_set = 1'b0;
    rx_par_set   = 1'b0;
    if (rx_state == S_IDLE) begin
      if (rx_en & rx_fall) begin
        rx_state_n = S_START;
        rx_cnt_n   = '0;
      end
    end else if (tick) begin
      rx_cnt_n = rx_cnt + 4'd1;
      // Mid-bit sample on the 8th tick of each bit.
      if (rx_cnt == 4'd7) begin
        case (rx_state)
          S_START:  if (rx_sync) rx_state_n = S_IDLE;   // false start
          S_DATA:   rx_shift_n = {rx_sync, rx_shift[7:1]};
          S_PARITY: rx_par_set = (rx_sync != (^rx_shift ^ par_odd));
          S_STOP: begin
            // Return to IDLE mid-stop so the next start edge is not missed.
            rx_push      = 1'b1;
            rx_frame_set = ~rx_sync;
            rx_state_n   = S_IDLE;
          end
          default: rx_state_n = S_IDLE;
        endcase
      end
      if (rx_cnt == 4'd15) begin
        case (rx_state)
          S_START: begin
            rx_state_n = S_DATA;
            rx_bit_n   = '0;
          end
          S_DATA: begin
            rx_bit_n = rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state_n = par_en ? S_PARITY : S_STOP;
          end
          S_PARITY: rx_state_n = S_STOP;
          default:  rx_state_n = rx_state;
        endcase
      end
    end
  end

  // Flags: a set on the same cycle as a write-1-to-clear wins.
  assign flag_set = {rx_par_set, rx_frame_set, rx_push & rx_full, wr_data & tx_full};
  assign flag_clr = wr_status ? wdata[7:4] : 4'b0;

  logic [8:0]            status;
  logic [DATA_WIDTH-1:0] read_val;
  assign status = {tx_busy, flags, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    read_val = '0;
    case (off)
      2'd0:    read_val[8:0]  = {~rx_empty, rx_empty ? 8'h00 : rx_rdata};
      2'd1:    read_val[8:0]  = status;
      2'd2:    read_val[6:0]  = ctrl;
      default: read_val[15:0] = baud_div;
    endcase
  end

  assign irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy) | (err_ie & |flags);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rdata     <= '0;
      ctrl      <= 7'b0000011;
      baud_div  <= BAUD_DIV_RST;
      baud_cnt  <= '0;
      flags     <= '0;
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_data   <= '0;
      txd       <= 1'b1;
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
    end else begin
      rsp_valid <= sel;
      rdata     <= (sel & ~we) ? read_val : '0;
      if (wr_ctrl) ctrl <= wdata[6:0];
      if (wr_baud) baud_div <= wdata[15:0];
      baud_cnt  <= (wr_baud | tick) ? 16'd0 : baud_cnt + 16'd1;
      flags     <= (flags & ~flag_clr) | flag_set;
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_bit    <= tx_bit_n;
      tx_data   <= tx_data_n;
      txd       <= txd_n;
      rx_meta   <= rxd;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_bit    <= rx_bit_n;
      rx_shift  <= rx_shift_n;
    end
  end
endmodule

// File: tb/tb_uart_periph.sv
// Directed + randomized bench for uart_periph. Expected serial frames and
// register values come from a frame-level model (bit lists, parity by
// population count, a queue of expected received bytes).
module tb_uart_periph;
  localparam logic [1:0] OFF_DATA = 2'd0, OFF_STATUS = 2'd1, OFF_CTRL = 2'd2, OFF_BAUD = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, req_valid, rsp_valid, txd, rxd, irq;
  logic        loop_en, rxd_drv;
  int          total = 0;
  int          bad   = 0;

  assign rxd = loop_en ? txd : rxd_drv;
  always #5 clk = ~clk;

  uart_periph dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
    .req_valid(req_valid), .rdata(rdata), .rsp_valid(rsp_valid),
    .txd(txd), .rxd(rxd), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [1:0] off, input logic w, input logic [31:0] d,
                     output logic [31:0] r);
    @(negedge clk);
    addr = {4'h1, 24'h0, off, 2'b00};
    we = w;
    wdata = d;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    r = rdata;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] r;
    bus(off, 1'b1, d, r);
    check("wr_rdata", r, 32'd0);
  endtask

  task automatic rd(input logic [1:0] off, input string tag, input logic [31:0] exp);
    logic [31:0] r;
    bus(off, 1'b0, 32'd0, r);
    check(tag, r, exp);
  endtask

  // Parity bit that makes the total count of ones even (or odd).
  function automatic logic par_bit(input logic [7:0] b, input logic odd);
    return (($countones(b) % 2) == 1) ^ odd;
  endfunction

  // Drive one serial frame on rxd, each bit 16*div clocks.
  task automatic drive_frame(input logic [7:0] b, input logic pen, input logic podd,
                             input logic flip_par, input logic stop, input int div);
    int bt;
    bt = 16 * div;
    rxd_drv = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (bt) @(negedge clk);
    end
    if (pen) begin
      rxd_drv = par_bit(b, podd) ^ flip_par;
      repeat (bt) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (bt) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b, b2;
    logic [7:0]  q[$];
    logic        found;
    logic [31:0] ctrl_v;
    int          div, n;

    reset = 1'b0; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    loop_en = 1'b0; rxd_drv = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 0);
    reset = 1'b1;

    // Unselected access has no effect and no response.
    @(negedge clk);
    addr = {4'h2, 24'h0, OFF_CTRL, 2'b00}; we = 1'b1; wdata = 32'h7F; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("unsel_rsp", rsp_valid, 0);
    rd(OFF_CTRL, "unsel_ctrl", 32'h03);

    // 1: reset in the middle of a frame.
    wr(OFF_DATA, 32'h00);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    check("t1_start_seen", found, 1);
    repeat (200) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("t1_txd_abort", txd, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("t1_txd_idle", txd, 1);
    rd(OFF_STATUS, "t1_status", 32'h00A);
    rd(OFF_CTRL, "t1_ctrl", 32'h03);
    rd(OFF_BAUD, "t1_baud", 32'd27);

    // 2: 0x55 at divisor 1, each bit 16 clocks, busy for 160 clocks.
    wr(OFF_BAUD, 32'd1);
    b = 8'h55;
    wr(OFF_DATA, {24'h0, b});
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    check("t2_start_seen", found, 1);
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 8 : 16) @(negedge clk);
      check($sformatf("t2_bit%0d", k), txd, (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
    end
    repeat (5) @(negedge clk);
    rd(OFF_STATUS, "t2_busy_159", 32'h10A);
    rd(OFF_STATUS, "t2_idle_161", 32'h00A);

    // 3: loopback, odd parity, back-to-back, then randomized rounds.
    loop_en = 1'b1;
    wr(OFF_BAUD, 32'd2);
    wr(OFF_CTRL, 32'h0F);
    wr(OFF_DATA, 32'hA5);
    wr(OFF_DATA, 32'h3C);
    repeat (2 * 12 * 32 + 60) @(negedge clk);
    rd(OFF_DATA, "t3_a5", 32'h1A5);
    rd(OFF_DATA, "t3_3c", 32'h13C);
    rd(OFF_STATUS, "t3_status", 32'h00A);
    for (int r = 0; r < 3; r++) begin
      ctrl_v = 32'h03 | ($urandom_range(0, 3) << 2);
      div = $urandom_range(1, 3);
      n = $urandom_range(1, 3);
      wr(OFF_BAUD, div);
      wr(OFF_CTRL, ctrl_v);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        q.push_back(b);
        wr(OFF_DATA, {24'h0, b});
      end
      repeat (n * 12 * 16 * div + 60) @(negedge clk);
      while (q.size() > 0) begin
        b = q.pop_front();
        rd(OFF_DATA, "t3_rand", {23'h0, 1'b1, b});
      end
      rd(OFF_STATUS, "t3_rand_status", 32'h00A);
    end
    loop_en = 1'b0;

    // 4: false start (low for 4 ticks at divisor 2).
    wr(OFF_BAUD, 32'd2);
    wr(OFF_CTRL, 32'h03);
    rxd_drv = 1'b0;
    repeat (8) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (200) @(negedge clk);
    rd(OFF_STATUS, "t4_status", 32'h00A);
    rd(OFF_DATA, "t4_empty_read", 32'h000);

    // 5: FIFO_DEPTH+1 frames with even parity -> overrun.
    wr(OFF_BAUD, 32'd1);
    wr(OFF_CTRL, 32'h07);
    for (int k = 0; k < 17; k++) begin
      b = 8'($urandom);
      q.push_back(b);
      drive_frame(b, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    end
    repeat (20) @(negedge clk);
    rd(OFF_STATUS, "t5_full_ovr", 32'h026);
    wr(OFF_STATUS, 32'h20);
    rd(OFF_STATUS, "t5_ovr_clr", 32'h006);
    wr(OFF_CTRL, 32'h17);
    check("t5_irq_rx", irq, 1);
    for (int k = 0; k < 16; k++) begin
      b = q.pop_front();
      rd(OFF_DATA, $sformatf("t5_byte%0d", k), {23'h0, 1'b1, b});
    end
    q.delete();
    rd(OFF_DATA, "t5_empty_read", 32'h000);
    rd(OFF_STATUS, "t5_status_end", 32'h00A);
    check("t5_irq_off", irq, 0);

    // Odd parity: one good frame, one with the parity bit flipped.
    wr(OFF_CTRL, 32'h0F);
    b  = 8'($urandom);
    b2 = 8'($urandom);
    drive_frame(b, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    drive_frame(b2, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    repeat (20) @(negedge clk);
    rd(OFF_STATUS, "t5_par_err", 32'h082);
    rd(OFF_DATA, "t5_par_good", {23'h0, 1'b1, b});
    rd(OFF_DATA, "t5_par_bad", {23'h0, 1'b1, b2});
    wr(OFF_STATUS, 32'h80);
    rd(OFF_STATUS, "t5_par_clr", 32'h00A);

    // 6: frame error with err_ie, then TX overflow with tx_en=0.
    wr(OFF_CTRL, 32'h43);
    b = 8'($urandom);
    drive_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    repeat (20) @(negedge clk);
    check("t6_irq_frame", irq, 1);
    rd(OFF_STATUS, "t6_frame_err", 32'h042);
    rd(OFF_DATA, "t6_frame_byte", {23'h0, 1'b1, b});
    wr(OFF_STATUS, 32'h40);
    rd(OFF_STATUS, "t6_frame_clr", 32'h00A);
    check("t6_irq_clr", irq, 0);
    wr(OFF_CTRL, 32'h42);
    for (int k = 0; k < 17; k++) wr(OFF_DATA, k);
    rd(OFF_STATUS, "t6_tx_ovf", 32'h019);
    check("t6_irq_ovf", irq, 1);
    wr(OFF_STATUS, 32'h10);
    wr(OFF_CTRL, 32'h20);
    check("t6_irq_tx_full", irq, 0);
    wr(OFF_CTRL, 32'h21);
    repeat (16 * 160 + 100) @(negedge clk);
    check("t6_irq_tx_done", irq, 1);
    rd(OFF_STATUS, "t6_status_end", 32'h00A);
    check("t6_txd_idle", txd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
